// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: button sync/debounce, per-frame sprite motion
// with hold-to-accelerate ramp, on-screen clamp and cursor select.
module sprite_motion_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int SPRITE_SIZE     = 50,
  parameter int INIT_X          = 50,
  parameter int INIT_Y          = 50,
  parameter int MAX_STEP        = 4,
  parameter int RAMP_FRAMES     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_end,
  input  logic       BTNU,
  input  logic       BTND,
  input  logic       BTNL,
  input  logic       BTNR,
  input  logic       BTNC,
  output logic [9:0] box_x,
  output logic [8:0] box_y,
  output logic       cursor_type,
  output logic       moved
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(MAX_STEP * RAMP_FRAMES) + 1;
  localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - SPRITE_SIZE);
  localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - SPRITE_SIZE);

  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [5:0]    raw;
  logic [5:0]    s1;
  logic [5:0]    s2;
  logic          fe_q3;
  logic          tick;
  logic [4:0]    deb;
  logic [CW-1:0] db_cnt [5];
  logic [HW-1:0] hold_cnt;
  logic          c_q;
  logic          up;
  logic          dn;
  logic          lf;
  logic          rt;
  logic          any_dir;
  logic [11:0]   ramp;
  logic signed [11:0] step;
  logic signed [11:0] nx;
  logic signed [11:0] ny;
  logic [9:0]    x_next;
  logic [8:0]    y_next;

  assign raw = {frame_end, BTNC, BTNR, BTNL, BTND, BTNU};
  assign rst_n = rst_sync[1];
  assign up = deb[0];
  assign dn = deb[1];
  assign lf = deb[2];
  assign rt = deb[3];
  assign any_dir = |deb[3:0];

  // Reset asserts at once, releases two clocks later in clk domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  // Two-flop synchronisers plus registered frame_end rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      fe_q3 <= 1'b0;
      tick  <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      fe_q3 <= s2[5];
      tick  <= s2[5] & ~fe_q3;
    end
  end

  // Debounce: level follows input after a full stable window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (s2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Step size from hold time, candidate position and clamp
  always_comb begin
    ramp = 12'(hold_cnt / HW'(RAMP_FRAMES)) + 12'd1;
    step = (ramp > 12'(MAX_STEP)) ? 12'(MAX_STEP) : $signed(ramp);
    nx = $signed({2'b00, box_x});
    ny = $signed({3'b000, box_y});
    unique case (1'b1)
      (rt & ~lf): nx = nx + step;
      (lf & ~rt): nx = nx - step;
      default: ;
    endcase
    unique case (1'b1)
      (dn & ~up): ny = ny + step;
      (up & ~dn): ny = ny - step;
      default: ;
    endcase
    x_next = (nx < 12'sd0) ? '0 :
             (nx > X_MAX) ? 10'(X_MAX) : nx[9:0];
    y_next = (ny < 12'sd0) ? '0 :
             (ny > Y_MAX) ? 9'(Y_MAX) : ny[8:0];
  end

  // Per-frame position update, hold ramp and moved pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_x    <= 10'(INIT_X);
      box_y    <= 9'(INIT_Y);
      hold_cnt <= '0;
      moved    <= 1'b0;
    end else begin
      moved <= 1'b0;
      if (tick) begin
        box_x <= x_next;
        box_y <= y_next;
        moved <= (x_next != box_x) || (y_next != box_y);
        if (!any_dir)             hold_cnt <= '0;
        else if (hold_cnt != '1)  hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

  // Cursor select flips once per debounced centre press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q         <= 1'b0;
      cursor_type <= 1'b0;
    end else begin
      c_q <= deb[4];
      if (deb[4] & ~c_q) cursor_type <= ~cursor_type;
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: directed checks of motion, ramp, clamp,
// debounce, opposing buttons, cursor select and async reset.
module tb_sprite_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_end = 1'b0;
  logic       BTNU = 1'b0;
  logic       BTND = 1'b0;
  logic       BTNL = 1'b0;
  logic       BTNR = 1'b0;
  logic       BTNC = 1'b0;
  logic [9:0] box_x;
  logic [8:0] box_y;
  logic       cursor_type;
  logic       moved;

  int vecs = 0;
  int errs = 0;

  localparam logic [4:0] B_U = 5'b00001;
  localparam logic [4:0] B_D = 5'b00010;
  localparam logic [4:0] B_L = 5'b00100;
  localparam logic [4:0] B_R = 5'b01000;
  localparam logic [4:0] B_C = 5'b10000;

  sprite_motion_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .frame_end(frame_end),
    .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNR(BTNR), .BTNC(BTNC),
    .box_x(box_x), .box_y(box_y),
    .cursor_type(cursor_type), .moved(moved)
  );

  always #5 clk = ~clk;

  task automatic set_btns(input logic [4:0] b);
    @(negedge clk);
    {BTNC, BTNR, BTNL, BTND, BTNU} = b;
    repeat (8) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    frame_end = 1'b0;
    {BTNC, BTNR, BTNL, BTND, BTNU} = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic do_frame(output int lat, output int np);
    lat = -1;
    np = 0;
    @(negedge clk);
    frame_end = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (moved === 1'b1) begin
        np++;
        if (lat < 0) lat = i;
      end
      if (i == 6) frame_end = 1'b0;
    end
  endtask

  task automatic test_reset();
    int lat, np;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      {BTNC, BTNR, BTNL, BTND, BTNU} = 5'(i * 7 + 3);
    end
    #1;
    vecs++; if (box_x !== 10'd50) begin errs++; $display("FAIL reset_x: got %0d expected 50", box_x); end
    vecs++; if (box_y !== 9'd50) begin errs++; $display("FAIL reset_y: got %0d expected 50", box_y); end
    vecs++; if (cursor_type !== 1'b0) begin errs++; $display("FAIL reset_cursor: got %b expected 0", cursor_type); end
    vecs++; if (moved !== 1'b0) begin errs++; $display("FAIL reset_moved: got %b expected 0", moved); end
    @(negedge clk);
    {BTNC, BTNR, BTNL, BTND, BTNU} = '0;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    for (int f = 0; f < 3; f++) begin
      do_frame(lat, np);
      vecs++; if (np !== 0) begin errs++; $display("FAIL idle_moved f%0d: got %0d pulses expected 0", f, np); end
    end
    vecs++; if (box_x !== 10'd50 || box_y !== 9'd50) begin errs++; $display("FAIL idle_pos: got %0d,%0d expected 50,50", box_x, box_y); end
  endtask

  task automatic test_right_ramp();
    int lat, np, st, ex;
    do_reset();
    set_btns(B_R);
    ex = 50;
    for (int k = 0; k < 20; k++) begin
      st = 1 + k / 8;
      if (st > 4) st = 4;
      ex += st;
      do_frame(lat, np);
      vecs++; if (lat !== 4 || np !== 1) begin errs++; $display("FAIL ramp_pulse f%0d: got lat %0d n %0d expected lat 4 n 1", k, lat, np); end
      vecs++; if (box_x !== 10'(ex)) begin errs++; $display("FAIL ramp_x f%0d: got %0d expected %0d", k, box_x, ex); end
    end
    vecs++; if (box_x !== 10'd86) begin errs++; $display("FAIL ramp_final_x: got %0d expected 86", box_x); end
    vecs++; if (box_y !== 9'd50) begin errs++; $display("FAIL ramp_y: got %0d expected 50", box_y); end
    set_btns('0);
    do_frame(lat, np);
  endtask

  task automatic test_clamp();
    int lat, np;
    do_reset();
    set_btns(B_L);
    for (int k = 0; k < 24; k++) do_frame(lat, np);
    vecs++; if (box_x !== 10'd2) begin errs++; $display("FAIL clamp_pre_x: got %0d expected 2", box_x); end
    do_frame(lat, np);
    vecs++; if (box_x !== 10'd0 || np !== 1) begin errs++; $display("FAIL clamp_x0: got %0d n %0d expected 0 n 1", box_x, np); end
    do_frame(lat, np);
    vecs++; if (box_x !== 10'd0 || np !== 0) begin errs++; $display("FAIL clamp_x_hold: got %0d n %0d expected 0 n 0", box_x, np); end
    set_btns('0);
    do_frame(lat, np);
    set_btns(B_D);
    for (int k = 0; k < 2; k++) do_frame(lat, np);
    set_btns('0);
    do_frame(lat, np);
    vecs++; if (box_y !== 9'd52) begin errs++; $display("FAIL clamp_y52: got %0d expected 52", box_y); end
    set_btns(B_D);
    for (int k = 0; k < 106; k++) do_frame(lat, np);
    vecs++; if (box_y !== 9'd428 || box_x !== 10'd0) begin errs++; $display("FAIL clamp_y428: got %0d,%0d expected 0,428", box_x, box_y); end
    do_frame(lat, np);
    vecs++; if (box_y !== 9'd430 || np !== 1) begin errs++; $display("FAIL clamp_y430: got %0d n %0d expected 430 n 1", box_y, np); end
    do_frame(lat, np);
    vecs++; if (box_y !== 9'd430 || np !== 0) begin errs++; $display("FAIL clamp_y_hold: got %0d n %0d expected 430 n 0", box_y, np); end
    set_btns('0);
    do_frame(lat, np);
  endtask

  task automatic test_debounce();
    int lat, np;
    do_reset();
    repeat (8) @(posedge clk);
    @(negedge clk);
    BTNU = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    BTNU = 1'b0;
    repeat (8) @(posedge clk);
    do_frame(lat, np);
    vecs++; if (box_y !== 9'd50 || np !== 0) begin errs++; $display("FAIL glitch: got y %0d n %0d expected 50 n 0", box_y, np); end
    @(negedge clk);
    BTNU = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    BTNU = 1'b0;
    do_frame(lat, np);
    vecs++; if (box_y !== 9'd49 || lat !== 4) begin errs++; $display("FAIL press6: got y %0d lat %0d expected 49 lat 4", box_y, lat); end
    repeat (8) @(posedge clk);
    do_frame(lat, np);
  endtask

  task automatic test_opposing();
    int lat, np, tot;
    do_reset();
    set_btns(B_U | B_D);
    tot = 0;
    for (int k = 0; k < 8; k++) begin
      do_frame(lat, np);
      tot += np;
    end
    vecs++; if (box_y !== 9'd50 || tot !== 0) begin errs++; $display("FAIL opp_hold: got y %0d n %0d expected 50 n 0", box_y, tot); end
    set_btns(B_D);
    do_frame(lat, np);
    vecs++; if (box_y !== 9'd52 || np !== 1) begin errs++; $display("FAIL opp_ramped: got y %0d n %0d expected 52 n 1", box_y, np); end
    vecs++; if (box_x !== 10'd50) begin errs++; $display("FAIL opp_x: got %0d expected 50", box_x); end
    set_btns('0);
    do_frame(lat, np);
  endtask

  task automatic test_cursor();
    int lat, np, tog;
    logic prev;
    do_reset();
    repeat (8) @(posedge clk);
    @(negedge clk);
    BTNC = 1'b1;
    tog = 0;
    prev = cursor_type;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (cursor_type !== prev) tog++;
      prev = cursor_type;
    end
    vecs++; if (tog !== 1 || cursor_type !== 1'b1) begin errs++; $display("FAIL cur_hold: got %0d toggles val %b expected 1 toggle val 1", tog, cursor_type); end
    @(negedge clk);
    BTNC = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    vecs++; if (cursor_type !== 1'b1) begin errs++; $display("FAIL cur_release: got %b expected 1", cursor_type); end
    @(negedge clk);
    BTNC = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    vecs++; if (cursor_type !== 1'b0) begin errs++; $display("FAIL cur_second: got %b expected 0", cursor_type); end
    @(negedge clk);
    BTNC = 1'b0;
    repeat (10) @(posedge clk);
    set_btns(B_R);
    @(negedge clk);
    BTNC = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    frame_end = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vecs++; if (cursor_type !== 1'b0 || box_x !== 10'd50) begin errs++; $display("FAIL coinc_pre: got cur %b x %0d expected 0 50", cursor_type, box_x); end
    @(posedge clk);
    #1;
    vecs++; if (cursor_type !== 1'b1 || box_x !== 10'd51 || moved !== 1'b1) begin errs++; $display("FAIL coinc: got cur %b x %0d mv %b expected 1 51 1", cursor_type, box_x, moved); end
    repeat (4) @(posedge clk);
    @(negedge clk);
    frame_end = 1'b0;
    BTNC = 1'b0;
    set_btns('0);
    do_frame(lat, np);
  endtask

  task automatic test_reset_mid_ramp();
    int lat, np;
    do_reset();
    set_btns(B_R);
    for (int k = 0; k < 12; k++) do_frame(lat, np);
    vecs++; if (box_x !== 10'd66) begin errs++; $display("FAIL mid_pre_x: got %0d expected 66", box_x); end
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    vecs++; if (box_x !== 10'd50 || moved !== 1'b0) begin errs++; $display("FAIL mid_async: got x %0d mv %b expected 50 0", box_x, moved); end
    @(negedge clk);
    reset = 1'b1;
    do_frame(lat, np);
    vecs++; if (box_x !== 10'd50 || np !== 0) begin errs++; $display("FAIL mid_redebounce: got x %0d n %0d expected 50 n 0", box_x, np); end
    do_frame(lat, np);
    vecs++; if (box_x !== 10'd51 || lat !== 4) begin errs++; $display("FAIL mid_step1: got x %0d lat %0d expected 51 lat 4", box_x, lat); end
    set_btns('0);
  endtask

  initial begin
    test_reset();
    test_right_ramp();
    test_clamp();
    test_debounce();
    test_opposing();
    test_cursor();
    test_reset_mid_ramp();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
- Upstream of the VGA display controller. It produces the sprite/box top-left position (box_x, box_y) and the cursor-type select.
- Inputs are the four Nexys A7 direction buttons plus the centre button, and the controller's screenEnd frame marker.
- It synchronises and debounces the buttons, and updates position once per frame with hold-to-accelerate speed ramping.
- It clamps the sprite fully on-screen, replacing the blocking per-frame update inside the display controller.

Parameters:
- DEBOUNCE_CYCLES, 1000000, clk cycles a synchronised button level must remain stable before the debounced level changes (10 ms at 100 MHz).
- SCREEN_W, 640, active width in pixels.
- SCREEN_H, 480, active height in pixels.
- SPRITE_SIZE, 50, sprite edge length in pixels.
- INIT_X, 50, reset x position.
- INIT_Y, 50, reset y position.
- MAX_STEP, 4, maximum pixels moved per frame per axis.
- RAMP_FRAMES, 8, held frames per +1 step increment.

Ports:
- clk  in  1  100 MHz system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- frame_end  in  1  screenEnd from the timing generator (clk25 domain, asynchronous to clk).
- BTNU  in  1  up button, raw.
- BTND  in  1  down button, raw.
- BTNL  in  1  left button, raw.
- BTNR  in  1  right button, raw.
- BTNC  in  1  centre button, raw.
- box_x  out  10  sprite left x, registered.
- box_y  out  9  sprite top y, registered.
- cursor_type  out  1  sprite select (1 = dash, 0 = dot), registered.
- moved  out  1  one-cycle pulse when a position update changed box_x or box_y.

Behaviour:
- Reset (reset low, async assert, sync deassert via clk): box_x = INIT_X, box_y = INIT_Y, cursor_type = 0, moved = 0. All synchroniser flops, debounced levels, debounce counters and hold_cnt are cleared to 0.
- Synchronisers: 2-flop synchroniser on each of the 5 buttons and on frame_end.
- Debounce, per button:
  - A counter increments while the synchronised level differs from the debounced level, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present, the debounced level takes the synchronised level and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Frame tick: one-clk pulse on the rising edge of synchronised frame_end (sync_q2 & ~sync_q3). The tick is asserted 3 clk edges after frame_end is first sampled high.
- Direction, from debounced levels:
  - dy = D − U; U and D together give dy = 0.
  - dx = R − L; L and R together give dx = 0.
- Speed ramp, evaluated on tick:
  - If any direction button is held, hold_cnt saturates-increments (width ≥ clog2(MAX_STEP·RAMP_FRAMES)+1). Otherwise hold_cnt = 0.
  - step = min(1 + hold_cnt_before_tick / RAMP_FRAMES, MAX_STEP).
- Position update, on tick only; registered, visible 1 clk after the tick:
  - Arithmetic is 12-bit signed: nx = box_x + dx·step, ny = box_y + dy·step.
  - Clamp nx to [0, SCREEN_W−SPRITE_SIZE] = [0, 590]; clamp ny to [0, SCREEN_H−SPRITE_SIZE] = [0, 430].
  - There is no wrap-around at any boundary.
- moved: 1 for exactly the cycle in which box_x or box_y takes a value different from its previous one; 0 otherwise, including ticks that hit a clamp.
- cursor_type: toggles 1 clk after each rising edge of debounced BTNC. It is independent of the frame tick; a held button toggles once.
- Simultaneous tick and BTNC edge: both take effect in the same cycle.
- Reset mid-operation: all state is immediately reinitialised; a press in progress must fully re-debounce after deassertion.

Test Plan (DEBOUNCE_CYCLES = 4 in simulation):
- Reset: hold reset low while buttons toggle -> box_x = 50, box_y = 50, cursor_type = 0, moved = 0; deassert with no buttons, 3 frame_end pulses -> positions unchanged, moved never asserted.
- Right held 20 frames from x = 50: steps 1×8, 2×8, 3×4 -> box_x = 50+8+16+12 = 86; moved pulses 20 times, each 4 clk after its frame_end rise; box_y stays 50.
- Clamp: x = 2, hold L ramping to step 4 -> box_x = 0 then stays 0, moved = 0 after reaching 0; from y = 428 hold D -> box_y = 430, never 431+.
- Debounce: 3-cycle BTNU glitch before frame_end -> no motion; 6-cycle press -> box_y decrements by 1 on the next frame.
- Opposing buttons: U+D held, L released -> box_y unchanged, hold_cnt still ramps; then D alone on the next frame uses the ramped step.
- BTNC held 100 cycles -> cursor_type toggles 0→1 once; released and pressed again -> 1→0; press coinciding with a tick -> position and cursor_type both update. Async reset mid-ramp -> hold_cnt = 0, next move is step 1.
